// File: rtl/mem_feed_ctrl_pkg.sv
// Shared constants and state encoding for the operand-memory feed controller.
package mem_feed_ctrl_pkg;

    localparam int unsigned DATA_WIDTH  = 8;
    localparam int unsigned DIM         = 4;
    localparam int unsigned FEED_CYCLES = 2 * DIM - 1;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned T_W         = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StFeed = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/mem_skew_sched.sv
// Skewed diagonal read schedule: column i reads row (t - i) while that row is in range.
module mem_skew_sched
    import mem_feed_ctrl_pkg::*;
(
    input  logic                   i_en,
    input  logic [T_W-1:0]         i_t,
    output logic [DIM-1:0]         o_re,
    output logic [2*DIM-1:0]       o_relem
);

    always_comb begin
        o_re    = '0;
        o_relem = '0;
        for (int i = 0; i < DIM; i++) begin
            // Unsigned wrap makes t < i land far above DIM, so one compare covers both bounds.
            if (i_en && ((4'(i_t) - 4'(i)) < 4'(DIM))) begin
                o_re[i]           = 1'b1;
                o_relem[2*i +: 2] = 2'(4'(i_t) - 4'(i));
            end
        end
    end

endmodule

// File: rtl/mem_feed_ctrl.sv
// Operand-memory sequencer: fills the 4x4 memory from a byte stream, then drives the
// skewed per-column read schedule for one feed pass and pulses done.
module mem_feed_ctrl
    import mem_feed_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load_valid,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    output logic                  o_load_ready,
    input  logic                  i_start,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_loaded,
    output logic                  o_done,
    output logic                  o_feed_valid,
    output logic                  o_mem_we,
    output logic [1:0]            o_mem_wline,
    output logic [1:0]            o_mem_welem,
    output logic [DATA_WIDTH-1:0] o_mem_din,
    output logic [DIM-1:0]        o_mem_re,
    output logic [2*DIM-1:0]      o_mem_relem
);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [T_W-1:0]   r_t;
    logic             r_loaded;
    logic             r_done;
    logic             w_beat;

    assign o_load_ready = (r_state == StIdle) || (r_state == StLoad);
    assign w_beat       = i_load_valid & o_load_ready;

    // The memory captures on the same edge, so the write port is driven combinationally.
    assign o_mem_we     = w_beat;
    assign o_mem_wline  = r_cnt[3:2];
    assign o_mem_welem  = r_cnt[1:0];
    assign o_mem_din    = i_load_data;

    assign o_busy       = (r_state != StIdle);
    assign o_feed_valid = (r_state == StFeed);
    assign o_loaded     = r_loaded;
    assign o_done       = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_t      <= '0;
            r_loaded <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_abort) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_t      <= '0;
            r_loaded <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    // A beat arriving with start is still written, but start takes priority.
                    if (i_start) begin
                        r_state <= StFeed;
                        r_t     <= '0;
                    end else if (w_beat) begin
                        r_state <= StLoad;
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                StLoad: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == 4'(DIM * DIM - 1)) begin
                            r_state  <= StIdle;
                            r_loaded <= 1'b1;
                        end
                    end
                end
                StFeed: begin
                    if (r_t == 3'(FEED_CYCLES - 1)) begin
                        r_state <= StDone;
                        r_t     <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_t <= r_t + 3'd1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    mem_skew_sched u_sched (
        .i_en    (r_state == StFeed),
        .i_t     (r_t),
        .o_re    (o_mem_re),
        .o_relem (o_mem_relem)
    );

endmodule

// File: tb/tb_mem_feed_ctrl.sv
// Scoreboard bench for mem_feed_ctrl with a behavioural 4x4 operand memory attached.
module tb_mem_feed_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_load_valid = 1'b0;
    logic [7:0] i_load_data = 8'h00;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic       o_load_ready, o_busy, o_loaded, o_done, o_feed_valid, o_mem_we;
    logic [1:0] o_mem_wline, o_mem_welem;
    logic [7:0] o_mem_din;
    logic [3:0] o_mem_re;
    logic [7:0] o_mem_relem;

    always #5 clk = ~clk;

    mem_feed_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_valid (i_load_valid),
        .i_load_data  (i_load_data),
        .o_load_ready (o_load_ready),
        .i_start      (i_start),
        .i_abort      (i_abort),
        .o_busy       (o_busy),
        .o_loaded     (o_loaded),
        .o_done       (o_done),
        .o_feed_valid (o_feed_valid),
        .o_mem_we     (o_mem_we),
        .o_mem_wline  (o_mem_wline),
        .o_mem_welem  (o_mem_welem),
        .o_mem_din    (o_mem_din),
        .o_mem_re     (o_mem_re),
        .o_mem_relem  (o_mem_relem)
    );

    // Operand memory: cleared on reset, written on the clock edge, column reads combinational.
    logic [7:0]  mem [4][4];
    logic [31:0] rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 4; l++)
                for (int e = 0; e < 4; e++)
                    mem[l][e] <= 8'h00;
        end else if (o_mem_we) begin
            mem[o_mem_wline][o_mem_welem] <= o_mem_din;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < 4; i++)
            if (o_mem_re[i]) rd_data[8*i +: 8] = mem[o_mem_relem[2*i +: 2]][i];
    end

    typedef struct packed {
        logic [1:0] line;
        logic [1:0] elem;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic [3:0]  re;
        logic [7:0]  relem;
        logic [31:0] data;
    } fd_t;

    wr_t        wr_q[$];
    fd_t        fd_q[$];
    logic [7:0] exp_mem [4][4];
    int         errors = 0;
    int         checks = 0;
    int         done_exp = 0;
    int         done_seen = 0;
    logic [4:0] prev_fv_re = '0;

    // Hand-derived diagonal schedule for t = 0..6.
    logic [3:0] re_tab    [7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    logic [7:0] relem_tab [7] = '{8'h00, 8'h01, 8'h06, 8'h1B, 8'h6C, 8'hB0, 8'hC0};

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int k, input logic [7:0] d);
        wr_t w;
        w.line = 2'(k >> 2);
        w.elem = 2'(k & 3);
        w.data = d;
        wr_q.push_back(w);
        exp_mem[k >> 2][k & 3] = d;
    endtask

    // Drive one beat with valid held; the caller decides when valid drops.
    task automatic beat(input int k, input logic [7:0] d);
        push_wr(k, d);
        i_load_valid = 1'b1;
        i_load_data  = d;
        step();
    endtask

    task automatic push_feed(input int n);
        fd_t f;
        for (int t = 0; t < n; t++) begin
            f.re    = re_tab[t];
            f.relem = relem_tab[t];
            f.data  = '0;
            for (int i = 0; i < 4; i++)
                if (f.re[i]) f.data[8*i +: 8] = exp_mem[f.relem[2*i +: 2]][i];
            fd_q.push_back(f);
        end
    endtask

    task automatic run_feed();
        push_feed(7);
        done_exp++;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int t = 0; t < 7; t++) step();
        chk("done_busy_in_done", {o_done, o_busy}, 2'b11);
        step();
        chk("idle_after_done", {o_done, o_busy, o_load_ready}, 3'b001);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes memory, feeds, or signals done.
    initial begin
        wr_t w;
        fd_t f;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_mem_we) begin
                    if (wr_q.size() == 0) begin
                        chk("write_expected", 40'(wr_q.size()), 40'd1);
                    end else begin
                        w = wr_q.pop_front();
                        chk("write_port", {o_mem_wline, o_mem_welem, o_mem_din}, w);
                    end
                end
                if (o_feed_valid) begin
                    if (fd_q.size() == 0) begin
                        chk("feed_expected", 40'(fd_q.size()), 40'd1);
                    end else begin
                        f = fd_q.pop_front();
                        chk("feed_sched", {o_mem_re, o_mem_relem}, {f.re, f.relem});
                        chk("feed_data", rd_data, f.data);
                    end
                end
                if (o_done) begin
                    done_seen++;
                    chk("done_after_last_feed", prev_fv_re, 5'h18);
                end
                prev_fv_re = {o_feed_valid, o_mem_re};
            end else begin
                prev_fv_re = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int l = 0; l < 4; l++)
            for (int e = 0; e < 4; e++)
                exp_mem[l][e] = 8'h00;

        step();
        step();
        // {busy, ready, done, feed_valid, re, relem, loaded, we}
        chk("reset_outputs", {o_busy, o_load_ready, o_done, o_feed_valid, o_mem_re,
                              o_mem_relem, o_loaded, o_mem_we}, 18'h10000);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Continuous load of 0x01..0x10.
        for (int k = 0; k < 16; k++) begin
            if (k == 8) chk("busy_in_load", o_busy, 1'b1);
            if (k == 15) chk("loaded_before_last", o_loaded, 1'b0);
            beat(k, 8'(k + 1));
        end
        i_load_valid = 1'b0;
        chk("loaded_after_16", {o_loaded, o_busy}, 2'b10);

        // Valid toggling every cycle: still exactly 16 accepted beats.
        for (int k = 0; k < 16; k++) begin
            beat(k, 8'(k + 1));
            i_load_valid = 1'b0;
            step();
        end
        chk("toggle_load_idle", {o_loaded, o_busy}, 2'b10);

        // Full feed pass over the loaded matrix.
        run_feed();

        // start and a beat in the same IDLE cycle: beat lands at mem[0][0], feed begins.
        push_wr(0, 8'hAA);
        push_feed(7);
        done_exp++;
        i_load_valid = 1'b1;
        i_load_data  = 8'hAA;
        i_start      = 1'b1;
        step();
        i_start     = 1'b0;
        i_load_data = 8'h55;
        for (int t = 0; t < 7; t++) begin
            chk("ready_low_in_feed", {o_load_ready, o_feed_valid}, 2'b01);
            step();
        end
        i_load_valid = 1'b0;
        chk("done_after_start_beat", {o_done, o_busy}, 2'b11);
        step();

        // Abort at t=3.
        push_feed(4);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int t = 0; t < 3; t++) step();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("after_abort", {o_busy, o_mem_re, o_loaded, o_feed_valid, o_done}, 8'h00);
        for (int t = 0; t < 3; t++) step();
        chk("no_done_after_abort", 40'(done_seen), 40'(done_exp));

        // Reset in the middle of a load.
        for (int k = 0; k < 5; k++) beat(k, 8'(8'h21 + k));
        i_load_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_load", {o_busy, o_load_ready, o_done, o_feed_valid, o_mem_re,
                               o_mem_relem, o_loaded, o_mem_we}, 18'h10000);
        for (int l = 0; l < 4; l++)
            for (int e = 0; e < 4; e++)
                exp_mem[l][e] = 8'h00;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        beat(0, 8'h77);
        i_load_valid = 1'b0;
        chk("restart_load", {o_busy, o_loaded}, 2'b10);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("abort_in_load", o_busy, 1'b0);

        // Feed with loaded=0: cleared memory plus the single new beat.
        run_feed();

        step();
        step();
        chk("wr_queue_drained", 40'(wr_q.size()), 40'd0);
        chk("feed_queue_drained", 40'(fd_q.size()), 40'd0);
        chk("done_count", 40'(done_seen), 40'(done_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
